tcbcnn_img_loader: RTL

- Upstream feeder for the TCB CNN top (tcbcnn).
- Accepts a 121-pixel x 8-bit image (11x11) as a stream of 32-bit words from the PS/AXI side and packs it into the 968-bit img vector.
- Fires a one-cycle valid into the CNN, waits for its ready, captures predict_number, and returns it to the host over a result handshake.

---
 rtl/tcbcnn_img_loader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/tcbcnn_img_loader.sv
// Image loader for the TCB CNN: packs 31 input words into the 968-bit image, starts the core,
// and returns its prediction. Optional watchdog is enabled by defining TCB_LOADER_TIMEOUT_EN.
module tcbcnn_img_loader #(
   parameter int unsigned PIX_W  = 8,
   parameter int unsigned N_PIX  = 121,
   parameter int unsigned WORD_W = 32
`ifdef TCB_LOADER_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYC = 4096
`endif
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [WORD_W-1:0]       s_data_i,
   input  logic                    s_valid_i,
   output logic                    s_ready_o,
   output logic [PIX_W*N_PIX-1:0]  img_out_o,
   output logic                    img_valid_o,
   input  logic                    core_ready_i,
   input  logic [31:0]             core_predict_i,
   output logic [31:0]             res_data_o,
   output logic                    res_valid_o,
   input  logic                    res_ready_i,
   output logic                    err_o
);

   localparam int unsigned IMG_W   = PIX_W * N_PIX;
   localparam int unsigned N_WORDS = (IMG_W + WORD_W - 1) / WORD_W;

   typedef enum logic [1:0] {StLoad, StFire, StWait, StResult} state_e;

   state_e              state_q, state_d;
   logic [4:0]          word_cnt_q, word_cnt_d;
   logic [IMG_W-1:0]    img_q, img_d;
   logic [31:0]         res_data_q, res_data_d;
   logic                s_ready_q, s_ready_d;
   logic                core_ready_q;
   logic                xfer, last_word, core_rise, timeout;
   logic [N_WORDS-1:0]  word_we;

   assign xfer      = (state_q == StLoad) && s_valid_i && s_ready_q;
   assign last_word = (word_cnt_q == 5'(N_WORDS - 1));
   // Only a rising edge counts, so a ready level left over from the last image is ignored.
   assign core_rise = core_ready_i && !core_ready_q;

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StLoad;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StLoad:   if (xfer && last_word) state_d = StFire;
         StFire:   state_d = StWait;
         StWait:   if (core_rise || timeout) state_d = StResult;
         StResult: if (res_ready_i) state_d = StLoad;
         default:  state_d = StLoad;
      endcase
   end

   // Output logic
   always_comb begin
      img_valid_o = 1'b0;
      res_valid_o = 1'b0;
      unique case (state_q)
         StFire:   img_valid_o = 1'b1;
         StResult: res_valid_o = 1'b1;
         default:  ;
      endcase
   end

   for (genvar k = 0; k < N_WORDS; k++) begin : g_word
      localparam int unsigned Lo = k * WORD_W;
      localparam int unsigned Wd = (IMG_W - Lo < WORD_W) ? (IMG_W - Lo) : WORD_W;
      assign word_we[k] = xfer && (word_cnt_q == 5'(k));
      // The final word may be partial; its unused upper bits are dropped.
      assign img_d[Lo +: Wd] = word_we[k] ? s_data_i[Wd-1:0] : img_q[Lo +: Wd];
   end

   always_comb begin
      word_cnt_d = word_cnt_q;
      res_data_d = res_data_q;
      if (xfer) begin
         word_cnt_d = word_cnt_q + 5'd1;
      end
      if (state_q == StWait) begin
         if (core_rise) begin
            res_data_d = core_predict_i;
         end else if (timeout) begin
            res_data_d = 32'hFFFF_FFFF;
         end
      end
      if ((state_q == StResult) && res_ready_i) begin
         word_cnt_d = '0;
      end
   end

   assign s_ready_d = (state_d == StLoad);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         word_cnt_q   <= '0;
         img_q        <= '0;
         res_data_q   <= '0;
         s_ready_q    <= 1'b0;
         core_ready_q <= 1'b0;
      end else begin
         word_cnt_q   <= word_cnt_d;
         img_q        <= img_d;
         res_data_q   <= res_data_d;
         s_ready_q    <= s_ready_d;
         core_ready_q <= core_ready_i;
      end
   end

`ifdef TCB_LOADER_TIMEOUT_EN
   logic [12:0] wd_cnt_q;
   logic        err_q;

   assign timeout = (state_q == StWait) && (wd_cnt_q == 13'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state_q == StFire) begin
            wd_cnt_q <= '0;
         end else if (state_q == StWait) begin
            wd_cnt_q <= wd_cnt_q + 13'd1;
         end
         // A completion on the timeout cycle wins; err stays sticky until reset.
         if (timeout && !core_rise) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err_o = err_q;
`else
   assign timeout = 1'b0;
   assign err_o   = 1'b0;
`endif

   assign s_ready_o  = s_ready_q;
   assign img_out_o  = img_q;
   assign res_data_o = res_data_q;

endmodule
